// File: rtl/load_store_unit.sv
// Load/store unit: turns MEM-stage load/store requests into word-indexed
// data memory read/write strobes. Sub-word stores use read-modify-write.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; req_ready high
// RD     | reading the addressed word (load, or first half of RMW store)
// WR     | writing the merged or full word
// RESP   | one-cycle completion pulse with rdata/err
module load_store_unit #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              req_err;
  logic [31:0]       req_index;
  logic [4:0]        lane_sh;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;
  logic [31:0]       shifted;
  logic [31:0]       load_val;

  // Request legality and word index of the incoming address
  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == SZ_HALF) & req_addr[0])
            | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
            | (req_addr[31:MEM_AW+2] != '0);
    req_index = {{(30-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
  end

  // Lane merge for sub-word stores and lane extraction for loads
  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_mask = (size_q == SZ_BYTE) ? (32'h0000_00FF << lane_sh)
                                    : (32'h0000_FFFF << lane_sh);
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    shifted   = word_q >> lane_sh;
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = word_q;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr[MEM_AW+1:0];
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d     = S_WR;
            mem_addr_d  = req_index;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = S_RD;
            mem_addr_d = req_index;
          end
        end
      end
      S_RD: begin
        word_d = mem_rdata;
        if (write_q) begin
          state_d     = S_WR;
          mem_wdata_d = merged;
        end else begin
          state_d = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched fields; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs decoded from state; strobes drop as soon as reset forces IDLE
  always_comb begin
    req_ready  = (state_q == S_IDLE) & rst_n;
    mem_read   = (state_q == S_RD);
    mem_write  = (state_q == S_WR);
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    resp_valid = (state_q == S_RESP);
    resp_err   = (state_q == S_RESP) & err_q;
    resp_rdata = ((state_q == S_RESP) && !err_q && !write_q) ? load_val : 32'h0;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-indexed data memory. It turns pipeline load/store requests into memory read and write strobes.
- Supports byte, halfword and word accesses, with sign/zero extension on loads and read-modify-write for sub-word stores.
- Sits between the MEM pipeline stage and the data memory. Performs alignment and range checks before any memory access.

Parameters:
- MEM_AW, 8, word-index width of the attached memory (2^MEM_AW words).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned, illegal size or out-of-range access.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable (memory writes on rising edge).
- mem_addr  output  32  word index: zero-extended req_addr[MEM_AW+1:2].
- mem_wdata  output  32  write data.
- mem_rdata  input  32  combinational read data; valid only while mem_read=1, high-Z otherwise.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all latched fields cleared.
  - req_ready=0 while rst_n=0, 1 after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation aborts the operation: a write strobe drops immediately and no write occurs at a following edge.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/size/signed/addr/wdata at the edge.
  - Error if any of: size=11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:MEM_AW+2]≠0.
  - Next state: error → RESP with resp_err=1; load or sub-word store → RD; word store → WR.
- RD:
  - mem_read=1, mem_addr=index.
  - mem_rdata captured into word_q at the edge.
  - Next state: load → RESP; store → WR.
- WR:
  - mem_write=1, mem_addr=index.
  - mem_wdata for word store = wdata.
  - mem_wdata for sub-word store = word_q with the addressed lanes replaced.
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata/resp_err valid in the same cycle.
  - Next state: IDLE. No response backpressure.
- Lane mapping is little-endian: byte offset k occupies bits 8k+7:8k; halfword offset 0 is bits 15:0, offset 2 is bits 31:16.
- Load extraction: right-justify the lane, then sign- or zero-extend per the latched req_signed. Word loads ignore req_signed.
- mem_read and mem_write are never high in the same cycle. Outside RD/WR both are 0 and mem_addr/mem_wdata hold their last value.
- Latency, counted as cycles after the accept edge until resp_valid:
  - load: 2 (RD, RESP);
  - word store: 2 (WR, RESP);
  - sub-word store: 3 (RD, WR, RESP);
  - error: 1 (RESP).
- Errored requests never assert mem_read or mem_write.
- Requests presented while req_ready=0 are ignored; the requester holds them until accepted.
- Maximum throughput: one request per 2 cycles, because an accept can occur only on the edge that leaves IDLE.

Test Plan:
- Word load, addr 0x000000D4, memory word 53 = 3:
  - RD cycle with mem_read=1, mem_addr=53;
  - next cycle resp_valid=1, resp_rdata=0x00000003, resp_err=0.
- Byte store, wdata 0x000000AB to addr 0x000000C9, word 50 = 0:
  - RD on word 50, then WR with mem_wdata=0x0000AB00;
  - then signed byte load from 0xC9 → 0xFFFFFFAB; unsigned byte load → 0x000000AB.
- Halfword store, wdata 0x00008001 to addr 0x000000D6, word 53 = 3:
  - mem_wdata=0x80010003;
  - signed half load 0xD6 → 0xFFFF8001; unsigned half load 0xD6 → 0x00008001.
- Error cases: word load 0xD5, half store 0xD7, size=11 at 0xD4, word load 0x00000400 (MEM_AW=8):
  - each gives resp_valid one cycle after accept with resp_err=1, resp_rdata=0;
  - mem_read and mem_write stay 0 throughout.
- Back-to-back word stores 0x11 → 0xC8 then 0x22 → 0xCC, req_valid held high:
  - second request accepted on the edge after RESP, when req_ready=1;
  - accepts are 3 cycles apart;
  - subsequent word loads return 0x11 and 0x22.
- Reset during WR of a byte store to 0xC8:
  - drive rst_n=0 mid-cycle: mem_write falls immediately; state goes to IDLE; no resp_valid;
  - word 50 keeps its old value; after release req_ready=1.
